// File: rtl/div_unit_pkg.sv
// Shared encodings for the execute-stage divider: FSM states, handshake
// levels and the ALU control codes that select DIV/DIVU.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
    localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, with the
// start/ready handshake to the hazard unit and flush (annul) abort.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    div_state_t  state, state_nxt;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic        sign_a, sign_b, sd_q;
    logic [63:0] final_res;

    logic [64:0] shifted;
    logic [32:0] diff;
    logic [64:0] step_work;
    logic [31:0] quo_fix, rem_fix;
    logic        last_step, accept, stop;

    assign accept    = start && !annul;
    assign stop      = annul || !start;
    assign last_step = (cnt == 6'd31);

    // Restoring step: a borrow out of the 33-bit subtract means "divisor didn't fit".
    assign shifted   = {work[63:0], 1'b0};
    assign diff      = shifted[64:32] - {1'b0, divisor};
    assign step_work = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};

    assign quo_fix = (sd_q && (sign_a ^ sign_b)) ? (~step_work[31:0] + 32'd1) : step_work[31:0];
    assign rem_fix = (sd_q && sign_a) ? (~step_work[63:32] + 32'd1) : step_work[63:32];

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_FREE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_FREE: begin
                if (accept) state_nxt = (opdata2 == 32'd0) ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: state_nxt = stop ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (stop)           state_nxt = DIV_FREE;
                else if (last_step) state_nxt = DIV_END;
            end
            DIV_END: begin
                if (stop) state_nxt = DIV_FREE;
            end
            default: state_nxt = DIV_FREE;
        endcase
    end

    // ready/result are registered one cycle behind entry into END.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            work      <= '0;
            divisor   <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            sd_q      <= 1'b0;
            final_res <= '0;
            result    <= '0;
            ready     <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    final_res <= '0;
                    result    <= '0;
                    ready     <= DIV_RESULT_NOT_READY;
                    if (accept && opdata2 != 32'd0) begin
                        work    <= {33'd0, signed_div ? abs32(opdata1) : opdata1};
                        divisor <= signed_div ? abs32(opdata2) : opdata2;
                        sign_a  <= opdata1[31];
                        sign_b  <= opdata2[31];
                        sd_q    <= signed_div;
                        cnt     <= '0;
                    end
                end
                DIV_ON: begin
                    result <= '0;
                    ready  <= DIV_RESULT_NOT_READY;
                    if (stop) begin
                        work <= '0;
                        cnt  <= '0;
                    end else begin
                        work <= step_work;
                        cnt  <= cnt + 6'd1;
                        if (last_step) final_res <= {rem_fix, quo_fix};
                    end
                end
                DIV_END: begin
                    if (stop) begin
                        result <= '0;
                        ready  <= DIV_RESULT_NOT_READY;
                    end else begin
                        result <= final_res;
                        ready  <= DIV_RESULT_READY;
                    end
                end
                default: begin
                    result <= '0;
                    ready  <= DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random DIV/DIVU
// ops checked against a 64-bit arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, signed_div, annul;
    logic [31:0] opdata1, opdata2;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic        ready_q = 1'b0;

    div_unit dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
        .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'h0;
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Monitor: each rising edge of ready consumes one expected result.
    always @(negedge clk) begin
        if (!rst && ready && !ready_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready got=%h want=none", result);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    errors++;
                    $display("FAIL result got=%h want=%h", result, e);
                end
            end
        end
        ready_q <= ready;
    end

    task automatic do_op(input bit sd, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        signed_div = sd; opdata1 = a; opdata2 = b; start = 1'b1;
        exp_q.push_back(model(sd, a, b));
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
            end
        end while (!ready && n < 60);
        chk("latency", 64'(n), (b == 32'd0) ? 64'd3 : 64'd34);
        start = 1'b0;
        @(posedge clk); #1;
        chk("ready_drop", {63'd0, ready}, 64'd0);
        chk("result_clear", result, 64'd0);
    endtask

    initial begin
        int nready;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk); rst = 1'b0;

        do_op(1'b0, 32'd100, 32'd7);
        do_op(1'b1, 32'hFFFFFFF9, 32'h2);
        do_op(1'b1, 32'd7, 32'hFFFFFFFE);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        do_op(1'b0, 32'hFFFFFFFF, 32'h1);
        do_op(1'b1, 32'd1234, 32'd0);

        // Flush mid-ON: no result may appear.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        nready = 0;
        repeat (45) begin
            @(negedge clk);
            if (ready) nready++;
        end
        chk("annul_no_ready", 64'(nready), 64'd0);
        do_op(1'b0, 32'd9, 32'd3);

        // Reset mid-ON.
        @(negedge clk);
        signed_div = 1'b1; opdata1 = 32'd77; opdata2 = 32'd3; start = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_result", result, 64'd0);
        @(negedge clk); rst = 1'b0; start = 1'b0;

        // Back-to-back DIVU, then random mix.
        do_op(1'b0, 32'd1000, 32'd33);
        do_op(1'b0, 32'hDEADBEEF, 32'h1234);
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -($urandom_range(1, 15));
                default: ;
            endcase
            do_op(1'($urandom), a, b);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
